// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, default register
// specifier width and the hard-wired zero register.
package pipe_ctrl_pkg;

    localparam int unsigned RWIDTH_DEF = 5;

    // $zero never creates a real dependency, so loads targeting it never stall.
    localparam logic [RWIDTH_DEF-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FREEZE   = 2'b10
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug: it sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [CNTW-1:0] count
);

    // Count enabled cycles and hold once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage semiMIPS pipe: load-use
// stalls, EX-resolved branch flushes and data-memory freezes, including a
// branch that resolves while the pipe is frozen.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RWIDTH = RWIDTH_DEF,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RWIDTH-1:0] id_rs,
    input  logic [RWIDTH-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [RWIDTH-1:0] ex_rt,
    input  logic              ex_branch_taken,
    input  logic              dmem_busy,
    output logic              pc_wr,
    output logic              ifid_wr,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [CNTW-1:0]   stall_cnt,
    output logic [CNTW-1:0]   flush_cnt
);

    state_t state;
    state_t state_nx;
    logic   pend_flush;
    logic   pend_flush_nx;

    logic   lu_hazard;
    logic   branch_now;
    logic   stall_en;
    logic   flush_en;
    logic   pc_wr_c;
    logic   ifid_wr_c;
    logic   ifid_flush_c;
    logic   idex_flush_c;

    // Load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_hazard = ex_memread
                  & (ex_rt != RWIDTH'(ZERO_REG))
                  & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // Next-state, pending-flush and output decode. A busy data memory
    // dominates every state; otherwise a live or pending branch beats a
    // load-use stall, and LU_STALL masks the hazard since EX holds a bubble.
    always_comb begin
        state_nx      = state;
        pend_flush_nx = pend_flush;
        stall_en      = 1'b0;
        flush_en      = 1'b0;
        pc_wr_c       = 1'b0;
        ifid_wr_c     = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        branch_now    = ex_branch_taken | ((state == FREEZE) & pend_flush);

        if (dmem_busy) begin
            state_nx = FREEZE;
            stall_en = 1'b1;
            if (ex_branch_taken) begin
                pend_flush_nx = 1'b1;
            end
        end else begin
            pend_flush_nx = 1'b0;
            if (branch_now) begin
                pc_wr_c      = 1'b1;
                ifid_wr_c    = 1'b1;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                flush_en     = 1'b1;
                state_nx     = RUN;
            end else if (lu_hazard && (state != LU_STALL)) begin
                idex_flush_c = 1'b1;
                stall_en     = 1'b1;
                state_nx     = LU_STALL;
            end else begin
                pc_wr_c   = 1'b1;
                ifid_wr_c = 1'b1;
                state_nx  = RUN;
            end
        end
    end

    // Registered FSM state and the pending flush captured during a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nx;
            pend_flush <= pend_flush_nx;
        end
    end

    // Reset gates the control outputs so the pipe holds while rst_n is low.
    always_comb begin
        pc_wr      = rst_n & pc_wr_c;
        ifid_wr    = rst_n & ifid_wr_c;
        ifid_flush = rst_n & ifid_flush_c;
        idex_flush = rst_n & idex_flush_c;
    end

    sat_counter #(.CNTW(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (stall_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_en),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-width instance for the control
// behaviour and a CNTW=2 instance for counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_b;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       dmem_busy;

    logic        pc_wr, ifid_wr, ifid_flush, idex_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_wr_b, ifid_wr_b, ifid_flush_b, idex_flush_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RWIDTH(5), .CNTW(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .pc_wr           (pc_wr),
        .ifid_wr         (ifid_wr),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    hazard_ctrl #(.RWIDTH(5), .CNTW(2)) dut_sat (
        .clk             (clk),
        .rst_n           (rst_b),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .pc_wr           (pc_wr_b),
        .ifid_wr         (ifid_wr_b),
        .ifid_flush      (ifid_flush_b),
        .idex_flush      (idex_flush_b),
        .stall_cnt       (stall_cnt_b),
        .flush_cnt       (flush_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Control outputs as {pc_wr, ifid_wr, ifid_flush, idex_flush}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_wr, ifid_wr, ifid_flush, idex_flush}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0;
        ex_branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        rst_b = 1'b0;
        dmem_busy = 1'b1;
        tick(); tick();
        chk_ctl("in_reset_outputs", 4'b0000);
        chk("in_reset_stall_cnt", 32'(stall_cnt), 32'd0);

        // Release reset: normal run values, counters clear.
        dmem_busy = 1'b0;
        rst_n = 1'b1;
        rst_b = 1'b1;
        #1;
        chk_ctl("after_reset_run", 4'b1100);
        chk("after_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("after_reset_flush_cnt", 32'(flush_cnt), 32'd0);

        // Load-use on rs.
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk_ctl("lu_rs_stall", 4'b0001);
        tick();
        chk("lu_rs_stall_cnt", 32'(stall_cnt), 32'd1);
        chk_ctl("lu_stall_masked", 4'b1100);
        idle_inputs();
        tick();

        // Load into $zero never stalls.
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk_ctl("lu_zero_no_stall", 4'b1100);
        tick();
        chk("lu_zero_stall_cnt", 32'(stall_cnt), 32'd1);

        // rt dependency only counts when rt is a source.
        ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk_ctl("rt_unused_no_stall", 4'b1100);
        id_uses_rt = 1'b1;
        #1;
        chk_ctl("rt_used_stall", 4'b0001);
        tick();
        chk("rt_stall_cnt", 32'(stall_cnt), 32'd2);
        idle_inputs();
        tick();

        // Taken branch wins over a concurrent load-use hazard.
        ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; ex_branch_taken = 1'b1;
        #1;
        chk_ctl("branch_over_lu", 4'b1111);
        tick();
        chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cnt), 32'd2);
        idle_inputs();
        #1;

        // Three-cycle freeze with a branch landing in the first cycle.
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk_ctl("freeze_c1", 4'b0000);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        chk_ctl("freeze_c2", 4'b0000);
        tick();
        chk_ctl("freeze_c3", 4'b0000);
        chk("freeze_no_early_flush", 32'(flush_cnt), 32'd1);
        tick();
        chk("freeze_stall_cnt", 32'(stall_cnt), 32'd5);
        dmem_busy = 1'b0;
        #1;
        chk_ctl("freeze_exit_flush", 4'b1111);
        tick();
        chk("freeze_exit_flush_cnt", 32'(flush_cnt), 32'd2);
        chk_ctl("after_freeze_normal", 4'b1100);
        tick();
        chk("after_freeze_flush_cnt", 32'(flush_cnt), 32'd2);

        // Asynchronous reset mid-freeze drops the pending flush.
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        tick();
        dmem_busy = 1'b0; ex_branch_taken = 1'b0;
        #1;
        chk_ctl("pending_exit_visible", 4'b1111);
        rst_n = 1'b0;
        #1;
        chk_ctl("async_reset_outputs", 4'b0000);
        chk("async_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async_reset_flush_cnt", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk_ctl("pending_lost", 4'b1100);
        tick();
        chk("pending_lost_flush_cnt", 32'(flush_cnt), 32'd0);

        // Saturation on the narrow instance: five freeze cycles stop at 3.
        rst_b = 1'b0;
        #1;
        rst_b = 1'b1;
        #1;
        chk("sat_start", 32'(stall_cnt_b), 32'd0);
        dmem_busy = 1'b1;
        #1;
        chk("sat_busy_outputs", {28'd0, pc_wr_b, ifid_wr_b, ifid_flush_b, idex_flush_b}, 32'd0);
        tick(); tick();
        chk("sat_count_2", 32'(stall_cnt_b), 32'd2);
        tick(); tick(); tick();
        chk("sat_count_hold", 32'(stall_cnt_b), 32'd3);
        chk("sat_wide_count", 32'(stall_cnt), 32'd5);
        chk("sat_flush_cnt", 32'(flush_cnt_b), 32'd0);
        dmem_busy = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
